// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with 1-cycle read latency.
// Optional per-requester grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,

    input  logic                  req0_valid_in,
    input  logic                  req0_write_in,
    input  logic [DATA_WIDTH-1:0] req0_addr_in,
    input  logic [DATA_WIDTH-1:0] req0_data_in,
    output logic                  req0_ready_out,
    output logic                  rsp0_valid_out,

    input  logic                  req1_valid_in,
    input  logic                  req1_write_in,
    input  logic [DATA_WIDTH-1:0] req1_addr_in,
    input  logic [DATA_WIDTH-1:0] req1_data_in,
    output logic                  req1_ready_out,
    output logic                  rsp1_valid_out,

    output logic [DATA_WIDTH-1:0] rsp_data_out,

    output logic                  mem_enable_out,
    output logic                  mem_rw_out,
    output logic [DATA_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,

    output logic [STAT_WIDTH-1:0] grant0_cnt_out,
    output logic [STAT_WIDTH-1:0] grant1_cnt_out
);

    logic grant0;
    logic grant1;
    logic last_grant_q;
    logic rd_pend_q;
    logic rd_owner_q;
    logic rd_grant;

    // Gated by reset so that no handshake can be observed while in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n_in) begin
            if (req0_valid_in && req1_valid_in) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid_in;
                grant1 = req1_valid_in;
            end
        end
    end

    assign req0_ready_out = grant0;
    assign req1_ready_out = grant1;

    always_comb begin
        mem_enable_out = grant0 | grant1;
        mem_rw_out     = 1'b0;
        mem_addr_out   = '0;
        mem_data_out   = '0;
        if (grant0) begin
            mem_rw_out   = req0_write_in;
            mem_addr_out = req0_addr_in;
            mem_data_out = req0_data_in;
        end else if (grant1) begin
            mem_rw_out   = req1_write_in;
            mem_addr_out = req1_addr_in;
            mem_data_out = req1_data_in;
        end
    end

    assign rd_grant = mem_enable_out & ~mem_rw_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                last_grant_q <= grant1;
            end
            rd_pend_q <= rd_grant;
            if (rd_grant) begin
                rd_owner_q <= grant1;
            end
        end
    end

    assign rsp0_valid_out = rd_pend_q & ~rd_owner_q;
    assign rsp1_valid_out = rd_pend_q & rd_owner_q;
    assign rsp_data_out   = mem_data_in;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grant0_cnt_q;
    logic [STAT_WIDTH-1:0] grant1_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
        end else begin
            if (grant0) begin
                grant0_cnt_q <= grant0_cnt_q + STAT_WIDTH'(1);
            end
            if (grant1) begin
                grant1_cnt_q <= grant1_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    assign grant0_cnt_out = grant0_cnt_q;
    assign grant1_cnt_out = grant1_cnt_q;
`else
    assign grant0_cnt_out = '0;
    assign grant1_cnt_out = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/counter sequences, and a randomized
// phase scored against a queue-based reference model with its own shadow memory.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          v0, w0, v1, w1;
    logic [DW-1:0] a0, d0, a1, d1;
    logic          rdy0, rdy1, rsp0, rsp1;
    logic [DW-1:0] rsp_data;
    logic          mem_en, mem_rw;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [SW-1:0] cnt0_o, cnt1_o;

    mem_arbiter #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .req0_valid_in(v0), .req0_write_in(w0), .req0_addr_in(a0), .req0_data_in(d0),
        .req0_ready_out(rdy0), .rsp0_valid_out(rsp0),
        .req1_valid_in(v1), .req1_write_in(w1), .req1_addr_in(a1), .req1_data_in(d1),
        .req1_ready_out(rdy1), .rsp1_valid_out(rsp1),
        .rsp_data_out(rsp_data),
        .mem_enable_out(mem_en), .mem_rw_out(mem_rw), .mem_addr_out(mem_addr),
        .mem_data_out(mem_wdata), .mem_data_in(mem_rdata),
        .grant0_cnt_out(cnt0_o), .grant1_cnt_out(cnt1_o)
    );

    // Attached memory: registered read; unwritten words read as 0x100 + index.
    logic [DW-1:0] mem [256];
    bit            written [256];
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) begin
                mem[mem_addr[7:0]]     <= mem_wdata;
                written[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]]
                                                    : 32'h100 + {24'h0, mem_addr[7:0]};
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rst;
        bit v0; bit w0; logic [DW-1:0] a0; logic [DW-1:0] d0;
        bit v1; bit w1; logic [DW-1:0] a1; logic [DW-1:0] d1;
        bit r0; bit r1; bit en; bit rw; logic [DW-1:0] addr; logic [DW-1:0] wd;
        bit s0; bit s1; logic [DW-1:0] rd;
    } vec_t;
    vec_t tbl [15];

    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t          exp_q [$];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ref_read(input logic [DW-1:0] addr);
        int idx = int'(addr[7:0]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h100 + addr;
    endfunction

    function automatic logic [SW-1:0] exp_cnt(input logic [SW-1:0] n);
`ifdef MEM_ARB_STATS_EN
        return n;
`else
        return (n == n) ? '0 : '0;
`endif
    endfunction

    task automatic idle_inputs();
        v0 = 0; w0 = 0; a0 = '0; d0 = '0;
        v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #4;
        chk("rst_en", mem_en, 0);
        chk("rst_rsp", {rsp0, rsp1}, 0);
        chk("rst_cnt", {cnt0_o, cnt1_o}, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    bit            tie_w, g0, g1, done0, done1, exp_rw;
    bit            s0e, s1e;
    logic [DW-1:0] exp_addr, exp_wd, exp_rd;
    logic [SW-1:0] cnt0, cnt1;
    rsp_t          e;

    initial begin
        tbl[0]  = '{0, 0,0,0,0,       0,0,0,0, 0,0,0,0,0,0,       0,0,0};
        tbl[1]  = '{0, 1,1,5,'hA5A5,  0,0,0,0, 1,0,1,1,5,'hA5A5,  0,0,0};
        tbl[2]  = '{0, 1,0,5,0,       0,0,0,0, 1,0,1,0,5,0,       0,0,0};
        tbl[3]  = '{0, 0,0,0,0,       0,0,0,0, 0,0,0,0,0,0,       1,0,'hA5A5};
        tbl[4]  = '{1, 1,0,5,0,       1,0,3,0, 0,0,0,0,0,0,       0,0,0};
        tbl[5]  = '{0, 1,0,5,0,       1,0,3,0, 1,0,1,0,5,0,       0,0,0};
        tbl[6]  = '{0, 1,0,6,0,       1,0,3,0, 0,1,1,0,3,0,       1,0,'hA5A5};
        tbl[7]  = '{0, 1,0,6,0,       1,0,4,0, 1,0,1,0,6,0,       0,1,'h103};
        tbl[8]  = '{0, 1,0,7,0,       1,0,4,0, 0,1,1,0,4,0,       1,0,'h106};
        tbl[9]  = '{0, 1,0,7,0,       0,0,0,0, 1,0,1,0,7,0,       0,1,'h104};
        tbl[10] = '{0, 0,0,0,0,       0,0,0,0, 0,0,0,0,0,0,       1,0,'h107};
        tbl[11] = '{0, 0,0,0,0,       1,0,3,0, 0,1,1,0,3,0,       0,0,0};
        tbl[12] = '{0, 0,0,0,0,       1,0,4,0, 0,1,1,0,4,0,       0,1,'h103};
        tbl[13] = '{0, 0,0,0,0,       0,0,0,0, 0,0,0,0,0,0,       0,1,'h104};
        tbl[14] = '{0, 0,0,0,0,       0,0,0,0, 0,0,0,0,0,0,       0,0,0};

        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        apply_reset();

        // Directed table: one row per cycle, outputs sampled just before the rising edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = !tbl[i].rst;
            v0 = tbl[i].v0; w0 = tbl[i].w0; a0 = tbl[i].a0; d0 = tbl[i].d0;
            v1 = tbl[i].v1; w1 = tbl[i].w1; a1 = tbl[i].a1; d1 = tbl[i].d1;
            #4;
            chk($sformatf("t%0d_rdy0", i), rdy0, tbl[i].r0);
            chk($sformatf("t%0d_rdy1", i), rdy1, tbl[i].r1);
            chk($sformatf("t%0d_en", i), mem_en, tbl[i].en);
            chk($sformatf("t%0d_rw", i), mem_rw, tbl[i].rw);
            chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("t%0d_wd", i), mem_wdata, tbl[i].wd);
            chk($sformatf("t%0d_rsp0", i), rsp0, tbl[i].s0);
            chk($sformatf("t%0d_rsp1", i), rsp1, tbl[i].s1);
            if (tbl[i].s0 || tbl[i].s1) chk($sformatf("t%0d_rdata", i), rsp_data, tbl[i].rd);
        end

        // Reset asserted while a read is in flight: its response must be dropped.
        @(negedge clk);
        v0 = 1; w0 = 0; a0 = 5;
        #4;
        chk("rstrd_rdy0", rdy0, 1);
        rst_n = 0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #4;
            chk($sformatf("rstrd_rsp_%0d", i), {rsp0, rsp1}, 0);
        end

        // 17 grants to requester 0 from reset; a 4-bit counter wraps to 1.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            v0 = 1; w0 = 1; a0 = 200 + i; d0 = i;
        end
        @(negedge clk);
        idle_inputs();
        #4;
        chk("cnt0_wrap", cnt0_o, exp_cnt(4'd1));
        chk("cnt1_zero", cnt1_o, 0);

        // Randomized traffic against the reference model.
        apply_reset();
        tie_w = 0; cnt0 = 0; cnt1 = 0; done0 = 0; done1 = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (done0) v0 = 0;
            if (done1) v1 = 0;
            if (!v0 && $urandom_range(0, 3) != 0) begin
                v0 = 1; w0 = 1'($urandom_range(0, 1));
                a0 = 32 + $urandom_range(0, 15); d0 = $urandom;
            end
            if (!v1 && $urandom_range(0, 3) != 0) begin
                v1 = 1; w1 = 1'($urandom_range(0, 1));
                a1 = 32 + $urandom_range(0, 15); d1 = $urandom;
            end
            #4;
            g0 = v0 && (!v1 || !tie_w);
            g1 = v1 && (!v0 || tie_w);
            exp_rw   = g0 ? w0 : (g1 ? w1 : 1'b0);
            exp_addr = g0 ? a0 : (g1 ? a1 : '0);
            exp_wd   = g0 ? d0 : (g1 ? d1 : '0);
            s0e = 0; s1e = 0; exp_rd = '0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s0e = !e.owner; s1e = e.owner; exp_rd = e.data;
            end
            chk("rnd_rdy0", rdy0, g0);
            chk("rnd_rdy1", rdy1, g1);
            chk("rnd_en", mem_en, g0 | g1);
            chk("rnd_rw", mem_rw, exp_rw);
            chk("rnd_addr", mem_addr, exp_addr);
            chk("rnd_wd", mem_wdata, exp_wd);
            chk("rnd_rsp0", rsp0, s0e);
            chk("rnd_rsp1", rsp1, s1e);
            if (s0e || s1e) chk("rnd_rdata", rsp_data, exp_rd);
            chk("rnd_cnt0", cnt0_o, exp_cnt(cnt0));
            chk("rnd_cnt1", cnt1_o, exp_cnt(cnt1));
            // The model advances as of the coming rising edge.
            if (g0 || g1) begin
                tie_w = g0;
                if (g0) cnt0 = cnt0 + 1'b1;
                if (g1) cnt1 = cnt1 + 1'b1;
                if (exp_rw) ref_mem[int'(exp_addr[7:0])] = exp_wd;
                else exp_q.push_back('{owner: g1, data: ref_read(exp_addr)});
            end
            done0 = g0;
            done1 = g1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
